uart_cmd_motor_ctrl: RTL and testbench
======================================

Name: uart_cmd_motor_ctrl

Overview:
- Consumes bytes from the UART receiver (RxData/RxDone) and decodes single-character ASCII commands.
- Drives the two motor outputs (motor1 = open direction, motor2 = close direction), stopping on the debounced limit switches finalcarrera1 (open end) and finalcarrera2 (closed end).
- Produces one-byte reply/status characters for the UART transmitter (TxData plus a valid/done handshake), which feeds the HC-06 link back to the phone.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: cycles a synchronised limit input must be stable before its debounced value changes.
- MOVE_TIMEOUT, 32'd500000000: maximum cycles in OPENING or CLOSING before a fault is declared.
- DEAD_CYCLES, 16'd5000: motor-off gap enforced on any direction reversal.

Ports:
- Clk  input  1  system clock; single clock domain
- Rst  input  1  asynchronous, active-high reset
- RxData  input  8  received byte; valid in the cycle RxDone=1
- RxDone  input  1  one-cycle pulse, byte received
- finalcarrera1  input  1  open-end limit switch, asynchronous, active-high
- finalcarrera2  input  1  closed-end limit switch, asynchronous, active-high
- TxDone  input  1  one-cycle pulse, transmitter finished current byte
- motor1  output  1  drive open direction
- motor2  output  1  drive close direction
- TxData  output  8  reply byte
- TxValid  output  1  reply byte presented, held until TxDone
- State  output  3  current FSM state code (debug/LED)
- Overflow  output  1  sticky: a reply was dropped; cleared by Rst only

Behaviour:
- Reset values: motor1=0, motor2=0, TxValid=0, TxData=8'h00, State=STOPPED (3'd0), Overflow=0. Debounced limits reset to 0. Reply queue is emptied.
- Limit inputs: 2-flop synchroniser, then a counter. The debounced value updates when the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free cycle restarts the count. Latency from the input edge is 2+DEBOUNCE_CYCLES cycles.
- Commands are sampled only when RxDone=1:
  - 'O' (8'h4F) = open
  - 'C' (8'h43) = close
  - 'S' (8'h53) = stop
  - '?' (8'h3F) = status
  - Any other byte replies 'E' (8'h45) and causes no state change.
- States: STOPPED=0, OPENING=1, CLOSING=2, DEADBAND=3, FAULT=4.
- Motor outputs are registered: motor1=1 only in OPENING, motor2=1 only in CLOSING. Both are never 1 in the same cycle.
- STOPPED:
  - 'O': if open limit is debounced-active, reply 'o' (8'h6F) and stay. Otherwise reply 'K' (8'h4B) and go to OPENING.
  - 'C': symmetric, using the close limit and reply 'c' (8'h63).
  - 'S': reply 'K'.
- OPENING:
  - Open limit active: go to STOPPED, reply 'o'.
  - 'S': go to STOPPED, reply 'K'.
  - 'O': reply 'K', no change.
  - 'C': reply 'K', go to DEADBAND with the pending direction set to close.
  - Timeout: go to FAULT, reply 'T' (8'h54).
- CLOSING: mirror image of OPENING.
- DEADBAND:
  - Motors stay off for DEAD_CYCLES cycles, then enter the pending direction.
  - If that direction's limit is already active at expiry, go to STOPPED and reply 'o' or 'c'.
  - 'S' during DEADBAND: go to STOPPED, reply 'K'.
  - 'O' or 'C' during DEADBAND: update the pending direction, reply 'K', do not restart the timer.
- Move timer: cleared on entry to OPENING or CLOSING. Fault when the count reaches MOVE_TIMEOUT.
- Both debounced limits active at once, in any non-FAULT state: go to FAULT and reply 'F' (8'h46). This takes priority over a command in the same cycle.
- FAULT: motors off. 'S' replies 'K' and goes to STOPPED. 'O' and 'C' reply 'E'.
- Status '?' is accepted in every state and does not change state. It replies with:
  - 'o' if the open limit is active
  - else 'c' if the close limit is active
  - else 'M' (8'h4D) if OPENING, CLOSING or DEADBAND
  - else 'X' (8'h58) if FAULT
  - else 'I' (8'h49).
- Same-cycle priority: limit/fault events beat commands. A limit reached in the same cycle as an 'O'/'C' command produces the limit reply only; the command is discarded.
- Reply queue:
  - 2-entry FIFO.
  - The head drives TxData. TxValid=1 whenever the FIFO is non-empty, asserted the cycle after the push.
  - A TxDone pulse pops the head. The next entry appears on the following cycle.
  - Push and pop in the same cycle are both honoured.
  - A push when full without a pop drops the new byte and sets Overflow.
  - TxDone while empty is ignored.
- Reset mid-move: motors drop to 0 asynchronously, the queue is flushed, and the block returns to STOPPED.

Test Plan:
Bench settings: DEBOUNCE_CYCLES=4, MOVE_TIMEOUT=200, DEAD_CYCLES=8. TxDone is pulsed 3 cycles after TxValid rises.
1. 'O' with both limits low: TxData=8'h4B, motor1=1. Raise finalcarrera1 and hold 6 cycles: motor1=0 within 2+4+1 cycles, reply 8'h6F, State=0.
2. 'O', then 'C' after 20 cycles: motor1 falls; both motors stay 0 for 8 cycles; then motor2=1. Replies are 8'h4B, 8'h4B.
3. 'C' with no limit ever: motor2 drops at cycle 200 of CLOSING, State=4, reply 8'h54. Then 'O' gives reply 8'h45 with motors 0. Then 'S' gives 8'h4B and State=0.
4. Bounce finalcarrera2 high for 3 cycles and then low, during CLOSING: no stop and no reply. Then a stable high: stop and reply 8'h63.
5. Three replies generated in consecutive cycles with TxDone held low ('?', 'Z', '?' back to back, with RxDone each cycle): the first two are queued, the third is dropped and Overflow=1. TxDone pulses then deliver 8'h49, then 8'h45.
6. Assert Rst during OPENING: motor1=0 in the same cycle (asynchronous), TxValid=0, State=0. After release, '?' replies 8'h49.

Source files
------------

// File: rtl/uart_cmd_motor_ctrl.sv
// Single-character UART command decoder driving an open/close motor pair.
// Debounced end stops, reversal dead band, move timeout and a 2-deep reply queue.
module uart_cmd_motor_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] MOVE_TIMEOUT    = 32'd500000000,
  parameter logic [15:0] DEAD_CYCLES     = 16'd5000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] RxData,
  input  logic       RxDone,
  input  logic       finalcarrera1,
  input  logic       finalcarrera2,
  input  logic       TxDone,
  output logic       motor1,
  output logic       motor2,
  output logic [7:0] TxData,
  output logic       TxValid,
  output logic [2:0] State,
  output logic       Overflow
);

  localparam logic [2:0] STOPPED  = 3'd0;
  localparam logic [2:0] OPENING  = 3'd1;
  localparam logic [2:0] CLOSING  = 3'd2;
  localparam logic [2:0] DEADBAND = 3'd3;
  localparam logic [2:0] FAULT    = 3'd4;

  localparam logic [7:0] CMD_OPEN   = 8'h4F;
  localparam logic [7:0] CMD_CLOSE  = 8'h43;
  localparam logic [7:0] CMD_STOP   = 8'h53;
  localparam logic [7:0] CMD_STATUS = 8'h3F;
  localparam logic [7:0] REP_OK     = 8'h4B;
  localparam logic [7:0] REP_OPEN   = 8'h6F;
  localparam logic [7:0] REP_CLOSE  = 8'h63;
  localparam logic [7:0] REP_ERR    = 8'h45;
  localparam logic [7:0] REP_TOUT   = 8'h54;
  localparam logic [7:0] REP_FAULT  = 8'h46;
  localparam logic [7:0] REP_MOVE   = 8'h4D;
  localparam logic [7:0] REP_FAULTS = 8'h58;
  localparam logic [7:0] REP_IDLE   = 8'h49;

  logic [1:0]  limRaw, limMeta, limSync, limDeb;
  logic [15:0] debCnt [2];

  assign limRaw = {finalcarrera2, finalcarrera1};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      limMeta   <= '0;
      limSync   <= '0;
      limDeb    <= '0;
      debCnt[0] <= '0;
      debCnt[1] <= '0;
    end else begin
      limMeta <= limRaw;
      limSync <= limMeta;
      for (int i = 0; i < 2; i++) begin
        if (limSync[i] == limDeb[i]) begin
          debCnt[i] <= '0;
        end else if (debCnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
          limDeb[i] <= limSync[i];
          debCnt[i] <= '0;
        end else begin
          debCnt[i] <= debCnt[i] + 16'd1;
        end
      end
    end
  end

  logic        openLim, closeLim;
  logic        cmdOpen, cmdClose, cmdStop, cmdStatus, cmdOther;
  logic [2:0]  state, nState;
  logic        pendClose, nPendClose;
  logic [31:0] moveCnt;
  logic [15:0] deadCnt;
  logic        moveExp, deadExp;
  logic        pushEn, evt;
  logic [7:0]  pushData, statusChar;

  assign openLim   = limDeb[0];
  assign closeLim  = limDeb[1];
  assign cmdOpen   = RxDone && (RxData == CMD_OPEN);
  assign cmdClose  = RxDone && (RxData == CMD_CLOSE);
  assign cmdStop   = RxDone && (RxData == CMD_STOP);
  assign cmdStatus = RxDone && (RxData == CMD_STATUS);
  assign cmdOther  = RxDone && !cmdOpen && !cmdClose
                     && !cmdStop && !cmdStatus;
  assign moveExp   = moveCnt == MOVE_TIMEOUT - 32'd1;
  assign deadExp   = deadCnt == DEAD_CYCLES - 16'd1;

  always_comb begin
    statusChar = REP_IDLE;
    if (openLim)                 statusChar = REP_OPEN;
    else if (closeLim)           statusChar = REP_CLOSE;
    else if (state == OPENING || state == CLOSING
             || state == DEADBAND) statusChar = REP_MOVE;
    else if (state == FAULT)     statusChar = REP_FAULTS;
  end

  // Limit, timeout and fault events are evaluated before any command.
  always_comb begin
    nState     = state;
    nPendClose = pendClose;
    pushEn     = 1'b0;
    pushData   = 8'h00;
    evt        = 1'b0;
    if (openLim && closeLim && state != FAULT) begin
      nState = FAULT; pushEn = 1'b1; pushData = REP_FAULT; evt = 1'b1;
    end else begin
      unique case (state)
        STOPPED: begin
          if (cmdOpen) begin
            pushEn = 1'b1;
            if (openLim) pushData = REP_OPEN;
            else begin pushData = REP_OK; nState = OPENING; end
          end else if (cmdClose) begin
            pushEn = 1'b1;
            if (closeLim) pushData = REP_CLOSE;
            else begin pushData = REP_OK; nState = CLOSING; end
          end else if (cmdStop) begin
            pushEn = 1'b1; pushData = REP_OK;
          end
        end
        OPENING: begin
          if (openLim) begin
            nState = STOPPED; pushEn = 1'b1; pushData = REP_OPEN; evt = 1'b1;
          end else if (moveExp) begin
            nState = FAULT; pushEn = 1'b1; pushData = REP_TOUT; evt = 1'b1;
          end else if (cmdStop) begin
            nState = STOPPED; pushEn = 1'b1; pushData = REP_OK;
          end else if (cmdOpen) begin
            pushEn = 1'b1; pushData = REP_OK;
          end else if (cmdClose) begin
            nState = DEADBAND; nPendClose = 1'b1;
            pushEn = 1'b1; pushData = REP_OK;
          end
        end
        CLOSING: begin
          if (closeLim) begin
            nState = STOPPED; pushEn = 1'b1; pushData = REP_CLOSE; evt = 1'b1;
          end else if (moveExp) begin
            nState = FAULT; pushEn = 1'b1; pushData = REP_TOUT; evt = 1'b1;
          end else if (cmdStop) begin
            nState = STOPPED; pushEn = 1'b1; pushData = REP_OK;
          end else if (cmdClose) begin
            pushEn = 1'b1; pushData = REP_OK;
          end else if (cmdOpen) begin
            nState = DEADBAND; nPendClose = 1'b0;
            pushEn = 1'b1; pushData = REP_OK;
          end
        end
        DEADBAND: begin
          if (deadExp && (pendClose ? closeLim : openLim)) begin
            nState = STOPPED; pushEn = 1'b1; evt = 1'b1;
            pushData = pendClose ? REP_CLOSE : REP_OPEN;
          end else if (cmdStop) begin
            nState = STOPPED; pushEn = 1'b1; pushData = REP_OK;
          end else begin
            if (cmdOpen || cmdClose) begin
              nPendClose = cmdClose; pushEn = 1'b1; pushData = REP_OK;
            end
            if (deadExp) nState = nPendClose ? CLOSING : OPENING;
          end
        end
        FAULT: begin
          if (cmdStop) begin
            nState = STOPPED; pushEn = 1'b1; pushData = REP_OK;
          end else if (cmdOpen || cmdClose) begin
            pushEn = 1'b1; pushData = REP_ERR;
          end
        end
        default: nState = STOPPED;
      endcase
    end
    if (!evt) begin
      if (cmdStatus) begin
        pushEn = 1'b1; pushData = statusChar;
      end else if (cmdOther) begin
        pushEn = 1'b1; pushData = REP_ERR;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= STOPPED;
      pendClose <= 1'b0;
      moveCnt   <= '0;
      deadCnt   <= '0;
      motor1    <= 1'b0;
      motor2    <= 1'b0;
    end else begin
      state     <= nState;
      pendClose <= nPendClose;
      motor1    <= nState == OPENING;
      motor2    <= nState == CLOSING;
      if (nState == state && (state == OPENING || state == CLOSING))
        moveCnt <= moveCnt + 32'd1;
      else
        moveCnt <= '0;
      if (nState == DEADBAND && state == DEADBAND)
        deadCnt <= deadCnt + 16'd1;
      else
        deadCnt <= '0;
    end
  end

  assign State = state;

  logic [7:0] fifoMem [2];
  logic       rdPtr, wrPtr;
  logic [1:0] fifoCnt;
  logic       pop, full, doPush;

  assign pop    = TxDone && (fifoCnt != 2'd0);
  assign full   = fifoCnt == 2'd2;
  assign doPush = pushEn && (!full || pop);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fifoMem[0] <= 8'h00;
      fifoMem[1] <= 8'h00;
      rdPtr      <= 1'b0;
      wrPtr      <= 1'b0;
      fifoCnt    <= 2'd0;
      Overflow   <= 1'b0;
    end else begin
      if (doPush) begin
        fifoMem[wrPtr] <= pushData;
        wrPtr          <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      fifoCnt <= fifoCnt + {1'b0, doPush} - {1'b0, pop};
      if (pushEn && !doPush) Overflow <= 1'b1;
    end
  end

  assign TxValid = fifoCnt != 2'd0;
  assign TxData  = TxValid ? fifoMem[rdPtr] : 8'h00;

endmodule

// File: tb/tb_uart_cmd_motor_ctrl.sv
// Directed bench for uart_cmd_motor_ctrl with shortened timing parameters.
module tb_uart_cmd_motor_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] RxData = 8'h00;
  logic       RxDone = 1'b0;
  logic       finalcarrera1 = 1'b0;
  logic       finalcarrera2 = 1'b0;
  logic       TxDone = 1'b0;
  logic       motor1, motor2, TxValid, Overflow;
  logic [7:0] TxData;
  logic [2:0] State;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  uart_cmd_motor_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .MOVE_TIMEOUT(32'd200),
    .DEAD_CYCLES(16'd8)
  ) dut (
    .Clk(Clk), .Rst(Rst), .RxData(RxData), .RxDone(RxDone),
    .finalcarrera1(finalcarrera1), .finalcarrera2(finalcarrera2),
    .TxDone(TxDone), .motor1(motor1), .motor2(motor2),
    .TxData(TxData), .TxValid(TxValid), .State(State),
    .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic doReset();
    Rst = 1'b1; RxDone = 1'b0; RxData = 8'h00; TxDone = 1'b0;
    finalcarrera1 = 1'b0; finalcarrera2 = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
  endtask

  task automatic sendByte(input logic [7:0] b);
    RxData = b; RxDone = 1'b1;
    @(negedge Clk);
    RxDone = 1'b0;
  endtask

  task automatic takeReply(output logic [7:0] d, output bit got);
    got = 1'b0; d = 8'h00;
    for (int i = 0; i < 50 && !got; i++) begin
      if (TxValid) got = 1'b1;
      else @(negedge Clk);
    end
    if (got) begin
      d = TxData;
      repeat (3) @(negedge Clk);
      TxDone = 1'b1;
      @(negedge Clk);
      TxDone = 1'b0;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    @(negedge Clk);
    tests++;
    if ({motor1, motor2, TxValid, Overflow} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 0000",
               {motor1, motor2, TxValid, Overflow});
    end
    tests++;
    if (TxData !== 8'h00 || State !== 3'd0) begin
      fails++;
      $display("FAIL reset_data: TxData=%h State=%0d expected 00/0", TxData, State);
    end
    doReset();
  endtask

  task automatic test_open_limit();
    logic [7:0] d; bit got; int k;
    doReset();
    sendByte(8'h4F);
    tests++;
    if (TxData !== 8'h4B || motor1 !== 1'b1 || State !== 3'd1) begin
      fails++;
      $display("FAIL open_start: TxData=%h motor1=%b State=%0d expected 4b/1/1",
               TxData, motor1, State);
    end
    takeReply(d, got);
    tests++;
    if (!got || d !== 8'h4B) begin
      fails++; $display("FAIL open_ack: got %h expected 4b", d);
    end
    finalcarrera1 = 1'b1;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge Clk);
      if (!motor1) k = i;
    end
    tests++;
    if (k !== 7) begin
      fails++; $display("FAIL open_limit_latency: got %0d cycles expected 7", k);
    end
    takeReply(d, got);
    tests++;
    if (!got || d !== 8'h6F || State !== 3'd0) begin
      fails++;
      $display("FAIL open_limit_reply: got %h State=%0d expected 6f/0", d, State);
    end
    finalcarrera1 = 1'b0;
  endtask

  task automatic test_reverse();
    logic [7:0] d; bit got; int zeros;
    doReset();
    sendByte(8'h4F);
    takeReply(d, got);
    tests++;
    if (!got || d !== 8'h4B) begin
      fails++; $display("FAIL rev_open_ack: got %h expected 4b", d);
    end
    sendByte(8'h3F);
    takeReply(d, got);
    tests++;
    if (!got || d !== 8'h4D) begin
      fails++; $display("FAIL status_moving: got %h expected 4d", d);
    end
    repeat (8) @(negedge Clk);
    sendByte(8'h43);
    zeros = 0;
    while (!motor1 && !motor2 && zeros < 30) begin
      zeros++;
      @(negedge Clk);
    end
    tests++;
    if (zeros !== 8 || motor2 !== 1'b1 || motor1 !== 1'b0) begin
      fails++;
      $display("FAIL rev_deadband: off=%0d m1=%b m2=%b expected 8/0/1",
               zeros, motor1, motor2);
    end
    takeReply(d, got);
    tests++;
    if (!got || d !== 8'h4B) begin
      fails++; $display("FAIL rev_close_ack: got %h expected 4b", d);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] d; bit got; int c0, c1;
    doReset();
    sendByte(8'h43);
    c0 = cyc;
    takeReply(d, got);
    for (int i = 0; i < 400 && motor2; i++) @(negedge Clk);
    c1 = cyc;
    tests++;
    if (c1 - c0 !== 200 || State !== 3'd4) begin
      fails++;
      $display("FAIL timeout_len: %0d cycles State=%0d expected 200/4", c1 - c0, State);
    end
    takeReply(d, got);
    tests++;
    if (!got || d !== 8'h54) begin
      fails++; $display("FAIL timeout_reply: got %h expected 54", d);
    end
    sendByte(8'h4F);
    tests++;
    if (motor1 !== 1'b0 || motor2 !== 1'b0) begin
      fails++; $display("FAIL fault_motors: m1=%b m2=%b expected 0/0", motor1, motor2);
    end
    takeReply(d, got);
    tests++;
    if (!got || d !== 8'h45) begin
      fails++; $display("FAIL fault_open_reply: got %h expected 45", d);
    end
    sendByte(8'h53);
    takeReply(d, got);
    tests++;
    if (!got || d !== 8'h4B || State !== 3'd0) begin
      fails++;
      $display("FAIL fault_clear: got %h State=%0d expected 4b/0", d, State);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] d; bit got; int k;
    doReset();
    sendByte(8'h43);
    takeReply(d, got);
    finalcarrera2 = 1'b1;
    repeat (3) @(negedge Clk);
    finalcarrera2 = 1'b0;
    repeat (10) @(negedge Clk);
    tests++;
    if (motor2 !== 1'b1 || TxValid !== 1'b0 || State !== 3'd2) begin
      fails++;
      $display("FAIL bounce_ignored: m2=%b TxValid=%b State=%0d expected 1/0/2",
               motor2, TxValid, State);
    end
    finalcarrera2 = 1'b1;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge Clk);
      if (!motor2) k = i;
    end
    takeReply(d, got);
    tests++;
    if (k !== 7 || !got || d !== 8'h63 || State !== 3'd0) begin
      fails++;
      $display("FAIL close_limit: lat=%0d got %h State=%0d expected 7/63/0",
               k, d, State);
    end
    finalcarrera2 = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] d; bit got;
    doReset();
    RxDone = 1'b1; RxData = 8'h3F;
    @(negedge Clk);
    RxData = 8'h5A;
    @(negedge Clk);
    RxData = 8'h3F;
    @(negedge Clk);
    RxDone = 1'b0;
    tests++;
    if (Overflow !== 1'b1) begin
      fails++; $display("FAIL overflow_flag: got %b expected 1", Overflow);
    end
    takeReply(d, got);
    tests++;
    if (!got || d !== 8'h49) begin
      fails++; $display("FAIL queue_first: got %h expected 49", d);
    end
    takeReply(d, got);
    tests++;
    if (!got || d !== 8'h45) begin
      fails++; $display("FAIL queue_second: got %h expected 45", d);
    end
    tests++;
    if (TxValid !== 1'b0 || Overflow !== 1'b1) begin
      fails++;
      $display("FAIL queue_drained: TxValid=%b Overflow=%b expected 0/1", TxValid, Overflow);
    end
  endtask

  task automatic test_reset_mid_move();
    logic [7:0] d; bit got;
    doReset();
    sendByte(8'h4F);
    tests++;
    if (motor1 !== 1'b1) begin
      fails++; $display("FAIL mid_move_start: motor1=%b expected 1", motor1);
    end
    #2 Rst = 1'b1;
    #1;
    tests++;
    if (motor1 !== 1'b0 || TxValid !== 1'b0 || State !== 3'd0) begin
      fails++;
      $display("FAIL async_reset: m1=%b TxValid=%b State=%0d expected 0/0/0",
               motor1, TxValid, State);
    end
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    sendByte(8'h3F);
    takeReply(d, got);
    tests++;
    if (!got || d !== 8'h49) begin
      fails++; $display("FAIL post_reset_status: got %h expected 49", d);
    end
  endtask

  initial begin
    test_reset();
    test_open_limit();
    test_reverse();
    test_timeout();
    test_bounce();
    test_overflow();
    test_reset_mid_move();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
